// File: rtl/aead_pkg.sv
// Shared widths, frame slice offsets and state encoding for the AEAD operand loader.
package aead_pkg;

    localparam int KEY_W   = 192;
    localparam int BLK_W   = 128;
    localparam int FRAME_W = KEY_W + 4 * BLK_W;

    // Fields are shifted in MS-first in the order K, S, NONCE, A, P, so K ends up on top.
    localparam int P_LSB     = 0;
    localparam int A_LSB     = P_LSB + BLK_W;
    localparam int NONCE_LSB = A_LSB + BLK_W;
    localparam int S_LSB     = NONCE_LSB + BLK_W;
    localparam int K_LSB     = S_LSB + BLK_W;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } loader_state_t;

endpackage

// File: rtl/aead_word_loader.sv
// Assembles a WORD_W-bit word stream into the K/S/NONCE/A/P operands of the Encrypt core.
// Optional macro LOADER_ZEROIZE_EN clears the frame register when the core reports done.
module aead_word_loader
    import aead_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              start,
    input  logic              enc_done,
    output logic              busy,
    output logic [KEY_W-1:0]  K,
    output logic [BLK_W-1:0]  S,
    output logic [BLK_W-1:0]  NONCE,
    output logic [BLK_W-1:0]  A,
    output logic [BLK_W-1:0]  P
);

    localparam int WORDS = FRAME_W / WORD_W;
    localparam int CNT_W = $clog2(WORDS);

    loader_state_t      state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [FRAME_W-1:0] frame_reg, frame_next;
    logic               first_run_reg, first_run_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= LOAD;
            count_reg     <= '0;
            frame_reg     <= '0;
            first_run_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            frame_reg     <= frame_next;
            first_run_reg <= first_run_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        frame_next     = frame_reg;
        first_run_next = 1'b0;
        case (state_reg)
            LOAD: begin
                if (in_valid) begin
                    frame_next = {frame_reg[FRAME_W-WORD_W-1:0], in_data};
                    if (count_reg == CNT_W'(WORDS - 1)) begin
                        count_next     = '0;
                        state_next     = RUN;
                        first_run_next = 1'b1;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                // A done still asserted from the previous frame is ignored on the first RUN cycle.
                if (enc_done && !first_run_reg) begin
                    state_next = LOAD;
`ifdef LOADER_ZEROIZE_EN
                    frame_next = '0;
`endif
                end
            end
            default: state_next = LOAD;
        endcase
    end

    assign in_ready = (state_reg == LOAD);
    assign start    = (state_reg == RUN);
    assign busy     = (state_reg == RUN);

    assign K     = frame_reg[K_LSB     +: KEY_W];
    assign S     = frame_reg[S_LSB     +: BLK_W];
    assign NONCE = frame_reg[NONCE_LSB +: BLK_W];
    assign A     = frame_reg[A_LSB     +: BLK_W];
    assign P     = frame_reg[P_LSB     +: BLK_W];

endmodule

// File: doc/aead_word_loader.md
# aead_word_loader

Input-side front end for the `Encrypt` AEAD core. It accepts a stream of `WORD_W`-bit words over a valid/ready handshake and assembles them into the core's parallel operands: K (192 b), S, NONCE, A and P (128 b each). When the frame is complete it raises `start` and holds it until the core reports `done`. While the core runs, the operands stay frozen.

## Interface
Parameters:
- `WORD_W`, 32: input word width. Legal values are 8, 16, 32 and 64; each must divide both 192 and 128.

Ports (reset is asynchronous and active-high; one clock):
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  word present on `in_data`.
- `in_data`  in  WORD_W  operand word.
- `in_ready`  out  1  loader can accept a word.
- `start`  out  1  launch request to `Encrypt`.
- `enc_done`  in  1  `done` from `Encrypt`.
- `busy`  out  1  high while a frame is loaded and running.
- `K`  out  192  key.
- `S`  out  128  S operand.
- `NONCE`  out  128  nonce.
- `A`  out  128  associated data.
- `P`  out  128  plaintext.

## Operation
- Frame = 704 bits in the fixed order K, S, NONCE, A, P.
  - Each field is sent most-significant word first.
  - WORDS = 704/WORD_W, which is 22 at WORD_W=32.
- One 704-bit frame register; the outputs are fixed slices of it:
  - K = [703:512], S = [511:384], NONCE = [383:256], A = [255:128], P = [127:0].
- Each accepted word (`in_valid && in_ready`) shifts the register left by WORD_W, with `in_data` entering at the LSBs. The word counter (width $clog2(WORDS)) increments.
- States:
  - LOAD: `in_ready`=1, `start`=0, `busy`=0. Acceptance of word WORDS-1 sets the counter to 0 and moves to RUN.
  - RUN: `in_ready`=0, `start`=1, `busy`=1. The frame register is frozen and `in_valid` is ignored. On the first RUN cycle, `enc_done` is ignored, which guards against a stale done from the previous frame. From the second cycle on, `enc_done`=1 moves to LOAD.
- Partial frames persist indefinitely. An `in_valid` gap does not reset the counter.
- Reset, including mid-LOAD or mid-RUN, forces:
  - state LOAD, counter 0, frame register 0;
  - `start`=0, `busy`=0, `in_ready`=1 after release.
- Output reset values: `start`=0, `busy`=0, `in_ready`=1, and K/S/NONCE/A/P all 0.

## Timing
- `start` is registered. If the last word is accepted at edge N, `start` and `busy` are high after edge N.
- If `enc_done` is sampled high at edge M (M ≥ N+2), then after edge M `start`=0, `busy`=0, `in_ready`=1.
- The next frame's first word can be accepted at edge M+1.
- `in_ready` is a function of state only; there is no combinational path from `in_valid`.
- Throughput is one word per cycle during LOAD.
- If `enc_done` is high on the first RUN cycle, it has no effect.
- If `enc_done` is high during LOAD, it is ignored.

## Configuration
- `LOADER_ZEROIZE_EN`:
  - Defined: the edge that leaves RUN on `enc_done` also clears the frame register to 0, so K and P are not retained after use.
  - Undefined: the frame register keeps the last frame until it is overwritten by shifting. Everything else is identical.

## Structure
- Package `aead_pkg`:
  - `KEY_W`=192, `BLK_W`=128, `FRAME_W`=704.
  - Slice-offset localparams for each field.
  - `loader_state_t` enum {LOAD, RUN}.
- Single module; no sub-module is needed. The counter and shift register are inline.

## Test plan
- Reset check: assert `rst` mid-frame after 10 words. Required: `in_ready`=1, all operands 0, and a full 22-word frame afterwards loads correctly.
- Nominal frame at WORD_W=32: send 22 words.
  - Operand values: K=0x68656c6c6f206d79206e616d6520697320736f67636f6e21, S=0x726f6265727420697320636f6f6c2021, NONCE=A=0x00646f6e277420726561642074686973, P=0x006e2774206465637279707420746873.
  - Required: exact operand values, and `start`=1 on the cycle after word 22.
- Backpressure: keep `in_valid`=1 with 5 extra words during RUN. Required: `in_ready`=0 and the operands are unchanged.
- Stale done: hold `enc_done`=1 on the first RUN cycle. Required: `start` stays 1. Then pulse `enc_done` 5 cycles later. Required: `start`=0 next cycle.
- Gapped input: insert random 0–3 cycle `in_valid` gaps. Required: the same operands as the nominal frame.
- With `LOADER_ZEROIZE_EN`: after `enc_done`, K and P read 0. Without it, they retain the frame values.
